// File: rtl/pspin_hostmem_rd_split.sv
// AXI read-channel splitter: cuts INCR read bursts at SPLIT_BYTES boundaries and
// stitches the R stream back so only the final beat of the original burst has rlast.
module pspin_hostmem_rd_split #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 8,
  parameter int ARUSER_WIDTH    = 1,
  parameter int RUSER_WIDTH     = 1,
  parameter int SPLIT_BYTES     = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  // upstream AR
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // upstream R
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // downstream AR
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // downstream R
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int SB_W = $clog2(SPLIT_BYTES);
  localparam int BW   = 13;  // holds SPLIT_BYTES (<=4096) plus a size rounding term
  localparam int PW   = $clog2(MAX_OUTSTANDING);
  localparam int CW   = PW + 1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic {IDLE, SPLIT} state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [ARUSER_WIDTH-1:0] user;
  } ar_t;

  state_e                 state_q, state_d;
  logic                   init_done_q;
  ar_t                    ar_q;
  logic [8:0]             rem_beats_q;
  logic [ADDR_WIDTH-1:0]  cur_addr_q;
  logic [ID_WIDTH-1:0]    active_id_q;
  logic [MAX_OUTSTANDING-1:0] fifo_last_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;

  logic                   fifo_full, fifo_empty, ar_hs, r_pop, sub_last;
  logic [ADDR_WIDTH-1:0]  size_mask, next_addr;
  logic [BW-1:0]          bytes_left, btb;
  logic [8:0]             sub_beats;

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // Sub-burst sizing: beats that fit before the next SPLIT_BYTES boundary.
  assign size_mask  = (ADDR_WIDTH'(1) << ar_q.size) - ADDR_WIDTH'(1);
  assign bytes_left = BW'(SPLIT_BYTES) - BW'(cur_addr_q[SB_W-1:0]);
  assign btb        = (bytes_left + size_mask[BW-1:0]) >> ar_q.size;
  assign sub_beats  = (ar_q.burst != BURST_INCR || BW'(rem_beats_q) <= btb) ? rem_beats_q : btb[8:0];
  assign sub_last   = (sub_beats == rem_beats_q);
  assign next_addr  = (cur_addr_q & ~size_mask) + (ADDR_WIDTH'(sub_beats) << ar_q.size);

  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_pop = m_axi_rvalid && s_axi_rready && m_axi_rlast && !fifo_empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d       = state_q;
    s_axi_arready = 1'b0;
    m_axi_arvalid = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi_arready = init_done_q;
        if (s_axi_arvalid && init_done_q) state_d = SPLIT;
      end
      SPLIT: begin
        // A different ID waits until every earlier sub-burst has fully returned.
        m_axi_arvalid = !fifo_full && (fifo_empty || ar_q.id == active_id_q);
        if (m_axi_arvalid && m_axi_arready && sub_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      init_done_q <= 1'b0;
      ar_q        <= '0;
      rem_beats_q <= '0;
      cur_addr_q  <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= 1'b1;
      if (s_axi_arvalid && s_axi_arready) begin
        ar_q        <= '{id: s_axi_arid, size: s_axi_arsize, burst: s_axi_arburst,
                         lock: s_axi_arlock, cache: s_axi_arcache, prot: s_axi_arprot,
                         qos: s_axi_arqos, region: s_axi_arregion, user: s_axi_aruser};
        rem_beats_q <= {1'b0, s_axi_arlen} + 9'd1;
        cur_addr_q  <= s_axi_araddr;
      end
      if (ar_hs) begin
        rem_beats_q <= rem_beats_q - sub_beats;
        cur_addr_q  <= next_addr;
        active_id_q <= ar_q.id;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (ar_hs) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (r_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({ar_hs, r_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: flag storage is not reset; entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (ar_hs) fifo_last_q[wr_ptr_q] <= sub_last;
  end

  assign m_axi_arid     = ar_q.id;
  assign m_axi_araddr   = cur_addr_q;
  assign m_axi_arlen    = 8'(sub_beats - 9'd1);
  assign m_axi_arsize   = ar_q.size;
  assign m_axi_arburst  = ar_q.burst;
  assign m_axi_arlock   = ar_q.lock;
  assign m_axi_arcache  = ar_q.cache;
  assign m_axi_arprot   = ar_q.prot;
  assign m_axi_arqos    = ar_q.qos;
  assign m_axi_arregion = ar_q.region;
  assign m_axi_aruser   = ar_q.user;

  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_ruser  = m_axi_ruser;
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;
  assign s_axi_rlast  = m_axi_rlast && !fifo_empty && fifo_last_q[rd_ptr_q];

  r_beat_without_ar_a: assert property (@(posedge clk) disable iff (!rstn)
    !(m_axi_rvalid && fifo_empty));

endmodule
